// File: rtl/gate_bist_pkg.sv
// Shared types and truth-table constants for the logic-gate BIST checker.
package gate_bist_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_e;

    localparam logic [3:0] AND2_TT  = 4'b1000;
    localparam logic [3:0] OR2_TT   = 4'b1110;
    localparam logic [3:0] XOR2_TT  = 4'b0110;
    localparam logic [3:0] NAND2_TT = 4'b0111;
    localparam logic [3:0] NOR2_TT  = 4'b0001;
    localparam logic [1:0] NOT_TT   = 2'b01;

    // Counter width able to hold HOLD_CYCLES-1, never narrower than one bit.
    function automatic int unsigned hold_w(input int unsigned h);
        return (h > 1) ? $clog2(h) : 1;
    endfunction

endpackage

// File: rtl/gate_bist_if.sv
// Stimulus/response and result bus between the BIST checker and its user.
interface gate_bist_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] stim;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            first_fail_valid;
    logic [N_IN-1:0] first_fail_vec;

    modport master (
        input  start, dut_out,
        output stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );

    modport slave (
        output start, dut_out,
        input  stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/gate_bist_hold_timer.sv
// Per-vector settle timer: counts APPLY cycles and flags the last one.
module gate_bist_hold_timer
    import gate_bist_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int unsigned HW = hold_w(HOLD_CYCLES);
    localparam logic [HW-1:0] LAST = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q == LAST);

    // Wraps to zero on expiry so the next vector starts a fresh hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = expire_o ? '0 : cnt_q + HW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/gate_bist_checker.sv
// Walks all input vectors of an N_IN-input gate, compares each settled output
// against TRUTH_TABLE and reports pass, mismatch count and first failing vector.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int                     N_IN        = 2,
    parameter int                     HOLD_CYCLES = 4,
    parameter logic [(1<<N_IN)-1:0]   TRUTH_TABLE = AND2_TT
) (
    input  logic        clk,
    input  logic        rst_n,
    gate_bist_if.master bus
);
    localparam int unsigned EW = N_IN + 1;

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN:0]   err_q, err_d;
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffvec_q, ffvec_d;
    logic            pass_q, pass_d;
    logic            hold_expire;
    logic            running;
    logic            mismatch;

    assign running = (state_q == APPLY) || (state_q == CHECK);

    gate_bist_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q != APPLY),
        .en_i     (state_q == APPLY),
        .expire_o (hold_expire)
    );

    // Case inequality so an X/Z gate output is scored as a mismatch.
    assign mismatch = (bus.dut_out !== TRUTH_TABLE[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = APPLY;
                    vec_d   = '0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                if (hold_expire)
                    state_d = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + EW'(1);
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_q;
                    end
                end
                if (vec_q == {N_IN{1'b1}}) begin
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.stim             = running ? vec_q : '0;
    assign bus.busy             = running;
    assign bus.done             = (state_q == DONE);
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;
endmodule

// File: doc/gate_bist_checker.md
# gate_bist_checker

Self-checking stimulus/response engine for the basic logic gate blocks. On a start pulse it walks every input combination of an N_IN-input gate, holds each vector for a settle interval, samples the gate output and compares it against a parameterised truth table. It then reports pass/fail, a mismatch count and the first failing vector. It sits beside the gate under check in the Basic Logic Gates area as a reusable, synthesizable replacement for hand-written stimulus sequences.

## Interface
Parameters:
- N_IN, 2, number of gate inputs (1..8)
- HOLD_CYCLES, 4, cycles each vector is driven before sampling (>=1)
- TRUTH_TABLE, 4'b1000, expected output; bit i = expected output for input vector i; width 2**N_IN (default = 2-input AND)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- stim  output  N_IN  drive to gate inputs; stim[0]=in1, stim[1]=in2, …
- dut_out  input  1  gate output under check
- busy  output  1  high from the cycle after start is accepted until DONE is entered
- done  output  1  high while in DONE
- pass  output  1  valid with done; 1 iff err_count==0
- err_count  output  N_IN+1  number of mismatching vectors; cannot overflow (max 2**N_IN)
- first_fail_valid  output  1  at least one mismatch recorded this run
- first_fail_vec  output  N_IN  vector index of the first mismatch

## Operation
- Reset: state IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, vector and hold counters=0.
- IDLE: start=1 -> APPLY with vec=0, hold=0. Accepting start also clears err_count, first_fail_*, pass and done.
- APPLY: stim=vec; hold increments each cycle; at hold==HOLD_CYCLES-1 -> CHECK.
- CHECK: stim still = vec. Compare dut_out with TRUTH_TABLE[vec] using 4-state inequality; X/Z counts as a mismatch.
  - On mismatch: err_count+1. If first_fail_valid==0, latch first_fail_vec=vec and set first_fail_valid.
  - If vec==2**N_IN-1 -> DONE. Otherwise vec+1, hold=0 -> APPLY.
- DONE: done=1 and pass=(err_count==0), both held; stim=0. start=1 -> restart exactly as from IDLE.
- start is ignored in APPLY/CHECK; no abort input exists. Only rst_n aborts a run.
- rst_n low in any state forces all reset values at that edge; a partial run is discarded.

## Timing
- Each vector occupies HOLD_CYCLES+1 cycles (HOLD_CYCLES in APPLY + 1 in CHECK).
- The edge that samples start is edge 0. stim=0 is visible after edge 0. done rises after edge 1+2**N_IN*(HOLD_CYCLES+1)-1 = 2**N_IN*(HOLD_CYCLES+1). Defaults: done high after edge 20.
- The gate output is sampled at the clock edge that ends CHECK. The gate path must settle within HOLD_CYCLES+1 cycles.
- err_count and first_fail_* update at the end-of-CHECK edge. done/pass update at the edge entering DONE.
- A restart from DONE drops done and busy rises at the same edge.

## Structure
- Shared package gate_bist_pkg:
  - state typedef enum {IDLE, APPLY, CHECK, DONE}
  - truth-table constants for the existing gates: AND2_TT=4'b1000, OR2_TT=4'b1110, XOR2_TT=4'b0110, NAND2_TT=4'b0111, NOR2_TT=4'b0001, NOT_TT=2'b01
- One natural sub-module, gate_bist_hold_timer: clear/enable counter asserting expire at HOLD_CYCLES-1. The FSM, vector counter and compare stay in the top.

## Test plan
- AND gate, TRUTH_TABLE=AND2_TT, HOLD_CYCLES=4, one-cycle start -> stim goes 0,1,2,3, each held 5 cycles; done after edge 20; pass=1, err_count=0, first_fail_valid=0.
- OR gate checked against AND2_TT -> mismatches at vectors 1 and 2; err_count=2, first_fail_vec=1, pass=0.
- dut_out tied 1, AND2_TT -> err_count=3, first_fail_vec=0; dut_out driven X only during vector 3 with a real AND -> err_count=1, first_fail_vec=3.
- start re-pulsed at cycle 7 of a run -> ignored, timing identical to scenario 1. start in DONE after a failing run -> done drops, err_count=0 and first_fail_valid=0 at that edge, full new run follows.
- rst_n low for one cycle during vector 2 APPLY -> all outputs at reset values the next cycle, state IDLE. Later start -> complete run from vector 0 with pass=1.
- N_IN=1, TRUTH_TABLE=NOT_TT, HOLD_CYCLES=1, NOT gate -> stim 0,1, each held 2 cycles; done after edge 4; pass=1.
